// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze > redirect > load-use.
// Define PIPE_CTRL_PERF_EN to build the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_load,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  input  logic        branch_taken,
  input  logic        dmem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        hazard_detection,
  output logic        idex_flush,
  output logic        stall_all,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t      state, state_next, ret_state, eff_state;
  logic [1:0]  flush_left, flush_left_next;
  logic [7:0]  wait_cnt, wait_inc;
  logic        mem_timeout_q;
  logic        lu;
  logic        stall_inc, flush_inc;
  logic        pc_we_c, ifid_we_c, ifid_flush_c, hazard_c, idex_flush_c, stall_all_c;

  assign lu = idex_load && (idex_rd != 5'd0) &&
              ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
               (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  assign wait_inc = (wait_cnt == 8'd255) ? 8'd255 : wait_cnt + 8'd1;

  always_comb begin
    state_next      = state;
    flush_left_next = flush_left;
    pc_we_c         = 1'b0;
    ifid_we_c       = 1'b0;
    ifid_flush_c    = 1'b0;
    hazard_c        = 1'b0;
    idex_flush_c    = 1'b0;
    stall_all_c     = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    // The first non-busy cycle after a wait behaves as the resumed state, so
    // a branch that was frozen in EX is acted on without an extra dead cycle.
    eff_state = (state == MEM_WAIT) ? ret_state : state;

    if (dmem_busy) begin
      stall_all_c = 1'b1;
      stall_inc   = 1'b1;
      state_next  = MEM_WAIT;
    end else begin
      case (eff_state)
        FLUSH: begin
          pc_we_c         = 1'b1;
          ifid_we_c       = 1'b1;
          ifid_flush_c    = 1'b1;
          idex_flush_c    = 1'b1;
          flush_left_next = (flush_left == 2'd0) ? 2'd0 : flush_left - 2'd1;
          state_next      = (flush_left <= 2'd1) ? RUN : FLUSH;
        end
        default: begin
          state_next = RUN;
          if (branch_taken) begin
            pc_we_c      = 1'b1;
            ifid_we_c    = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next      = FLUSH;
              flush_left_next = 2'(FLUSH_CYCLES - 1);
            end
          end else if (lu) begin
            hazard_c  = 1'b1;
            stall_inc = 1'b1;
          end else begin
            pc_we_c   = 1'b1;
            ifid_we_c = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      ret_state     <= RUN;
      flush_left    <= 2'd0;
      wait_cnt      <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state      <= state_next;
      flush_left <= flush_left_next;
      if (dmem_busy && (state != MEM_WAIT))
        ret_state <= state;
      if (dmem_busy) begin
        wait_cnt <= wait_inc;
        if (wait_inc == 8'(MEM_TIMEOUT))
          mem_timeout_q <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  assign pc_we            = pc_we_c      & ~rst;
  assign ifid_we          = ifid_we_c    & ~rst;
  assign ifid_flush       = ifid_flush_c & ~rst;
  assign hazard_detection = hazard_c     & ~rst;
  assign idex_flush       = idex_flush_c & ~rst;
  assign stall_all        = stall_all_c  & ~rst;
  assign mem_timeout      = mem_timeout_q & ~rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (stall_inc) stall_q <= stall_q + 32'd1;
      if (flush_inc) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_perf;
  assign unused_perf = stall_inc ^ flush_inc;
  assign stall_cnt   = 32'h0;
  assign flush_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance FLUSH_CYCLES=2, MEM_TIMEOUT=4,
// plus a default-parameter instance for the single-cycle redirect.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl vector bit order: {pc_we, ifid_we, ifid_flush, hazard_detection, idex_flush, stall_all}
  localparam logic [5:0] C_RUN  = 6'b110000;
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_FL   = 6'b111010;
  localparam logic [5:0] C_BUSY = 6'b000001;
  localparam logic [5:0] C_OFF  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_load, ifid_use_rs1, ifid_use_rs2, branch_taken, dmem_busy;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        pc_we, ifid_we, ifid_flush, hazard_detection, idex_flush, stall_all, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic        d2_pc_we, d2_ifid_we, d2_ifid_flush, d2_hazard, d2_idex_flush, d2_stall_all, d2_mem_timeout;
  logic [31:0] d2_stall_cnt, d2_flush_cnt;
  logic [5:0]  ctl, d2_ctl;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic [31:0] exp_sc, exp_fc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .idex_load(idex_load), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .hazard_detection(hazard_detection), .idex_flush(idex_flush), .stall_all(stall_all),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl d2 (
    .clk(clk), .rst(rst), .idex_load(idex_load), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_we(d2_pc_we), .ifid_we(d2_ifid_we), .ifid_flush(d2_ifid_flush),
    .hazard_detection(d2_hazard), .idex_flush(d2_idex_flush), .stall_all(d2_stall_all),
    .mem_timeout(d2_mem_timeout), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  assign ctl    = {pc_we, ifid_we, ifid_flush, hazard_detection, idex_flush, stall_all};
  assign d2_ctl = {d2_pc_we, d2_ifid_we, d2_ifid_flush, d2_hazard, d2_idex_flush, d2_stall_all};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    idex_load = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0; branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #2;
    tests++;
    if (ctl !== C_OFF || mem_timeout !== 1'b0) begin
      fails++; $display("FAIL reset_outputs ctl=%b tmo=%b expected ctl=%b tmo=0", ctl, mem_timeout, C_OFF);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    tests++;
    if (ctl !== C_RUN) begin
      fails++; $display("FAIL reset_release ctl=%b expected %b", ctl, C_RUN);
    end
    tests++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_counters stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    step();
    idex_load = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
    #1;
    tests++;
    if (ctl !== C_LU) begin
      fails++; $display("FAIL lu_rs2 ctl=%b expected %b", ctl, C_LU);
    end
    step(); exp_stall++;
    idex_load = 0;
    #1;
    exp_sc = PERF ? exp_stall : 32'd0;
    tests++;
    if (ctl !== C_RUN || stall_cnt !== exp_sc) begin
      fails++; $display("FAIL lu_release ctl=%b stall=%0d expected ctl=%b stall=%0d", ctl, stall_cnt, C_RUN, exp_sc);
    end
    idex_load = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1; ifid_rs2 = 0;
    #1;
    tests++;
    if (ctl !== C_RUN) begin
      fails++; $display("FAIL lu_rd_zero ctl=%b expected %b", ctl, C_RUN);
    end
    idex_rd = 7; ifid_rs1 = 7; ifid_use_rs1 = 0; ifid_rs2 = 3; ifid_use_rs2 = 1;
    #1;
    tests++;
    if (ctl !== C_RUN) begin
      fails++; $display("FAIL lu_unused_rs1 ctl=%b expected %b", ctl, C_RUN);
    end
    ifid_use_rs1 = 1;
    #1;
    tests++;
    if (ctl !== C_LU) begin
      fails++; $display("FAIL lu_rs1 ctl=%b expected %b", ctl, C_LU);
    end
    step(); exp_stall++;
    set_idle();
    #1;
    exp_sc = PERF ? exp_stall : 32'd0;
    tests++;
    if (stall_cnt !== exp_sc) begin
      fails++; $display("FAIL lu_count stall=%0d expected %0d", stall_cnt, exp_sc);
    end
  endtask

  task automatic test_redirect();
    branch_taken = 1;
    #1;
    tests++;
    if (ctl !== C_FL || d2_ctl !== C_FL) begin
      fails++; $display("FAIL redirect_c1 ctl=%b d2=%b expected %b", ctl, d2_ctl, C_FL);
    end
    step(); exp_flush++;
    // branch held high: ignored by the FLUSH state of the 2-cycle instance
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL redirect_c2 ctl=%b expected %b", ctl, C_FL);
    end
    step();
    branch_taken = 0;
    #1;
    exp_fc = PERF ? exp_flush : 32'd0;
    tests++;
    if (ctl !== C_RUN || d2_ctl !== C_RUN || flush_cnt !== exp_fc) begin
      fails++; $display("FAIL redirect_end ctl=%b d2=%b flush=%0d expected ctl=%b flush=%0d", ctl, d2_ctl, flush_cnt, C_RUN, exp_fc);
    end
  endtask

  task automatic test_branch_with_lu();
    branch_taken = 1; idex_load = 1; idex_rd = 9; ifid_rs1 = 9; ifid_use_rs1 = 1;
    #1;
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL br_lu_c1 ctl=%b expected %b", ctl, C_FL);
    end
    step(); exp_flush++;
    branch_taken = 0;
    #1;
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL br_lu_c2 ctl=%b expected %b", ctl, C_FL);
    end
    step();
    set_idle();
    #1;
    exp_sc = PERF ? exp_stall : 32'd0;
    exp_fc = PERF ? exp_flush : 32'd0;
    tests++;
    if (ctl !== C_RUN || stall_cnt !== exp_sc || flush_cnt !== exp_fc) begin
      fails++; $display("FAIL br_lu_end ctl=%b stall=%0d flush=%0d expected ctl=%b stall=%0d flush=%0d", ctl, stall_cnt, flush_cnt, C_RUN, exp_sc, exp_fc);
    end
  endtask

  task automatic test_mem_wait();
    dmem_busy = 1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      tests++;
      if (ctl !== C_BUSY) begin
        fails++; $display("FAIL mem_wait_c%0d ctl=%b expected %b", k, ctl, C_BUSY);
      end
      step(); exp_stall++;
    end
    dmem_busy = 0;
    #1;
    exp_sc = PERF ? exp_stall : 32'd0;
    tests++;
    if (ctl !== C_RUN || stall_cnt !== exp_sc || mem_timeout !== 1'b0) begin
      fails++; $display("FAIL mem_wait_end ctl=%b stall=%0d tmo=%b expected ctl=%b stall=%0d tmo=0", ctl, stall_cnt, mem_timeout, C_RUN, exp_sc);
    end
    step();
  endtask

  task automatic test_timeout();
    dmem_busy = 1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      tests++;
      if (ctl !== C_BUSY) begin
        fails++; $display("FAIL tmo_busy_c%0d ctl=%b expected %b", k, ctl, C_BUSY);
      end
      step(); exp_stall++;
      tests++;
      if (mem_timeout !== (k >= 4)) begin
        fails++; $display("FAIL tmo_flag_c%0d tmo=%b expected %b", k, mem_timeout, (k >= 4));
      end
    end
    dmem_busy = 0;
    step();
    exp_sc = PERF ? exp_stall : 32'd0;
    tests++;
    if (ctl !== C_RUN || mem_timeout !== 1'b1 || stall_cnt !== exp_sc) begin
      fails++; $display("FAIL tmo_sticky ctl=%b tmo=%b stall=%0d expected ctl=%b tmo=1 stall=%0d", ctl, mem_timeout, stall_cnt, C_RUN, exp_sc);
    end
  endtask

  task automatic test_simultaneous();
    dmem_busy = 1; branch_taken = 1; idex_load = 1; idex_rd = 4; ifid_rs2 = 4; ifid_use_rs2 = 1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      tests++;
      if (ctl !== C_BUSY) begin
        fails++; $display("FAIL sim_freeze_c%0d ctl=%b expected %b", k, ctl, C_BUSY);
      end
      step(); exp_stall++;
    end
    dmem_busy = 0;
    #1;
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL sim_release_flush ctl=%b expected %b", ctl, C_FL);
    end
    step(); exp_flush++;
    set_idle();
    #1;
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL sim_flush_c2 ctl=%b expected %b", ctl, C_FL);
    end
    step();
    // freeze landing inside FLUSH must resume the remaining flush cycle
    branch_taken = 1;
    step(); exp_flush++;
    branch_taken = 0; dmem_busy = 1;
    #1;
    tests++;
    if (ctl !== C_BUSY) begin
      fails++; $display("FAIL flush_freeze ctl=%b expected %b", ctl, C_BUSY);
    end
    step(); exp_stall++;
    dmem_busy = 0;
    #1;
    tests++;
    if (ctl !== C_FL) begin
      fails++; $display("FAIL flush_resume ctl=%b expected %b", ctl, C_FL);
    end
    step();
    exp_sc = PERF ? exp_stall : 32'd0;
    exp_fc = PERF ? exp_flush : 32'd0;
    tests++;
    if (ctl !== C_RUN || stall_cnt !== exp_sc || flush_cnt !== exp_fc) begin
      fails++; $display("FAIL sim_end ctl=%b stall=%0d flush=%0d expected ctl=%b stall=%0d flush=%0d", ctl, stall_cnt, flush_cnt, C_RUN, exp_sc, exp_fc);
    end
  endtask

  task automatic test_reset_mid_wait();
    dmem_busy = 1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (ctl !== C_OFF || mem_timeout !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      fails++; $display("FAIL rst_mid_wait ctl=%b tmo=%b stall=%0d flush=%0d expected all 0", ctl, mem_timeout, stall_cnt, flush_cnt);
    end
    dmem_busy = 0;
    exp_stall = 0; exp_flush = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    tests++;
    if (ctl !== C_RUN) begin
      fails++; $display("FAIL rst_release ctl=%b expected %b", ctl, C_RUN);
    end
    step();
    tests++;
    if (ctl !== C_RUN || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      fails++; $display("FAIL rst_after ctl=%b stall=%0d flush=%0d expected ctl=%b 0/0", ctl, stall_cnt, flush_cnt, C_RUN);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_branch_with_lu();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the IF/ID and ID/EX control pins: PC write enable, IF/ID write and flush, the ID/EX bubble (`hazard_detection`) and the ID/EX flush. It resolves three hazard sources with a fixed priority:

1. data-memory wait
2. taken branch/jump redirect
3. load-use

It also provides optional performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles for which IF/ID and ID/EX are flushed after a redirect. Range 1–4.
- `MEM_TIMEOUT`, default 255: number of consecutive `MEM_WAIT` cycles after which `mem_timeout` is raised. Range 1–255.

Ports:
- `clk`, in, 1: the single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `idex_load`, in, 1: the instruction in EX is a load.
- `idex_rd`, in, 5: destination register of the instruction in EX.
- `ifid_rs1`, in, 5: source register 1 of the instruction in ID.
- `ifid_rs2`, in, 5: source register 2 of the instruction in ID.
- `ifid_use_rs1`, in, 1: the ID instruction reads rs1.
- `ifid_use_rs2`, in, 1: the ID instruction reads rs2.
- `branch_taken`, in, 1: redirect resolved in EX.
- `dmem_busy`, in, 1: data memory is not ready; the whole pipeline must freeze.
- `pc_we`, out, 1: PC register write enable.
- `ifid_we`, out, 1: IF/ID write enable.
- `ifid_flush`, out, 1: clear IF/ID.
- `hazard_detection`, out, 1: insert a bubble into ID/EX (controls zeroed, data passes).
- `idex_flush`, out, 1: clear ID/EX completely. Connects to the `NextPCSrc_in` pin of ID/EX.
- `stall_all`, out, 1: hold ID/EX, EX/MEM and MEM/WB.
- `mem_timeout`, out, 1: sticky error flag.
- `stall_cnt`, out, 32: load-use plus memory-wait stall cycles counted.
- `flush_cnt`, out, 32: number of redirects accepted.

## Operation
- FSM states: `RUN`, `FLUSH`, `MEM_WAIT`.
- Registers: `state`, `ret_state` (the state to resume after `MEM_WAIT`), `flush_left` (2 bits), `wait_cnt` (8 bits), `mem_timeout`, and the counters.
- Load-use condition, `lu`:
  - `lu` = `idex_load` & (`idex_rd` ≠ 0) & ((`ifid_use_rs1` & `idex_rd` == `ifid_rs1`) | (`ifid_use_rs2` & `idex_rd` == `ifid_rs2`)).
- Outputs are decoded combinationally from `state` and the inputs. Priority per cycle, highest first:
  - `dmem_busy` = 1 (any state): `stall_all` = 1, `pc_we` = `ifid_we` = 0, all flushes and bubbles 0.
    - Next state `MEM_WAIT`.
    - `ret_state` is latched only on entry from `RUN` or `FLUSH`.
  - `branch_taken` = 1 in `RUN`: `pc_we` = 1, `ifid_flush` = 1, `idex_flush` = 1.
    - If `FLUSH_CYCLES` > 1: go to `FLUSH` with `flush_left` = `FLUSH_CYCLES`−1.
    - `flush_cnt` increments by 1.
  - `lu` in `RUN`: `pc_we` = 0, `ifid_we` = 0, `hazard_detection` = 1.
    - State stays `RUN`; exactly one bubble is inserted per load.
    - `stall_cnt` increments by 1.
  - `RUN`, no event: `pc_we` = `ifid_we` = 1, everything else 0.
- `FLUSH` state (no `dmem_busy`): `pc_we` = `ifid_we` = 1, `ifid_flush` = `idex_flush` = 1.
  - `branch_taken` and `lu` are ignored, because the stages hold squashed instructions.
  - `flush_left` decrements each cycle; when it reaches 0, go to `RUN`.
- `MEM_WAIT` state:
  - `wait_cnt` increments each cycle and saturates at 255.
  - `stall_cnt` increments each cycle.
  - When `wait_cnt` reaches `MEM_TIMEOUT`, `mem_timeout` is set. It stays set until `rst`.
  - When `dmem_busy` falls: return to `ret_state` with `flush_left` unchanged, and clear `wait_cnt`.
  - The EX-stage branch is frozen during the wait, so a pending `branch_taken` is evaluated on the first cycle after return.

## Timing
- Reset (asynchronous, immediate):
  - State: `state` = `RUN`, `ret_state` = `RUN`, `flush_left` = 0, `wait_cnt` = 0, `mem_timeout` = 0.
  - Counters: `stall_cnt` = `flush_cnt` = 0.
  - While `rst` = 1, all outputs are forced to 0, including `pc_we` and `ifid_we`.
- Control outputs have zero latency: they are valid in the same cycle as the inputs and are sampled by the pipeline registers at the next rising edge.
- Load-use costs exactly 1 cycle. The bubble is visible in EX one edge later, at which point `idex_load` = 0 and the stall releases.
- A redirect costs `FLUSH_CYCLES` cycles of flush.
- `dmem_busy` asserted for N cycles freezes the pipeline for exactly N cycles.
- Simultaneous events:
  - `dmem_busy` together with `branch_taken` or `lu`: only the freeze occurs. The other event is re-evaluated after the wait.
  - `branch_taken` together with `lu`: the redirect wins and no stall is counted.
- `rst` asserted mid-`FLUSH` or mid-`MEM_WAIT`: return to `RUN` immediately; the remaining flush count is discarded.
- Counters wrap at 2^32.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cnt` and `flush_cnt` are implemented as described above.
- `PIPE_CTRL_PERF_EN` undefined: both outputs are tied to 32'h0 and no counter flops are generated.
- Hazard behaviour is identical in both builds.

## Test plan
- **Load-use:** `idex_load` = 1, `idex_rd` = 5, `ifid_rs2` = 5, `ifid_use_rs2` = 1, in `RUN` → for one cycle `pc_we` = 0, `ifid_we` = 0, `hazard_detection` = 1; `stall_cnt` = 1. With `idex_rd` = 0 → no stall.
- **Redirect:** `branch_taken` = 1 with `FLUSH_CYCLES` = 2 → `ifid_flush` = `idex_flush` = 1 for 2 consecutive cycles, `pc_we` = 1 throughout, `flush_cnt` = 1. A second `branch_taken` during the `FLUSH` cycle is ignored.
- **Memory wait and timeout:** `dmem_busy` high for 3 cycles → `stall_all` = 1 and `pc_we` = 0 for exactly 3 cycles, then `RUN`, `stall_cnt` = 3. With `MEM_TIMEOUT` = 4 and `dmem_busy` held for 6 cycles → `mem_timeout` = 1 on the 4th cycle, and it stays 1 after busy drops.
- **Simultaneous events:**
  - `dmem_busy`, `branch_taken` and `lu` all asserted → freeze only.
  - On release with `branch_taken` still 1 → flush on the first `RUN` cycle.
  - `branch_taken` with `lu` → flush, `stall_cnt` unchanged.
- **Reset:** `rst` pulsed mid-`MEM_WAIT` at a non-clock-edge time → all outputs 0 immediately; after release, `pc_we` = `ifid_we` = 1 and counters = 0.
- **Build without `PIPE_CTRL_PERF_EN`:** repeat the redirect scenario → `flush_cnt` = 0 and `stall_cnt` = 0, with identical control waveforms.
